// File: rtl/sdram_arbiter_pkg.sv
// Shared types and widths for the SDRAM user-port arbiter and its helpers.
package sdram_arbiter_pkg;

    localparam int RAM_ADDR_W = 32;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } arb_state_t;

    typedef struct packed {
        logic [3:0]            wr;
        logic                  rd;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_cmd_t;

    function automatic logic req_active(input logic [3:0] wr, input logic rd);
        return rd | (|wr);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side signals of the shared SDRAM user port.
interface sdram_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import sdram_arbiter_pkg::*;

    logic [4*NUM_REQ-1:0]          req_wr_i;
    logic [NUM_REQ-1:0]            req_rd_i;
    logic [RAM_ADDR_W*NUM_REQ-1:0] req_addr_i;
    logic [RAM_DATA_W*NUM_REQ-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]            req_accept_o;
    logic [NUM_REQ-1:0]            req_ack_o;
    logic [NUM_REQ-1:0]            req_err_o;
    logic [RAM_DATA_W-1:0]         req_rdata_o;

    logic [3:0]                    ram_wr_o;
    logic                          ram_rd_o;
    logic [RAM_ADDR_W-1:0]         ram_addr_o;
    logic [RAM_DATA_W-1:0]         ram_write_data_o;
    logic [RAM_DATA_W-1:0]         ram_read_data_i;
    logic                          ram_accept_i;
    logic                          ram_ack_i;
    logic                          ram_error_i;

    modport slave (
        input  req_wr_i, req_rd_i, req_addr_i, req_wdata_i,
        output req_accept_o, req_ack_o, req_err_o, req_rdata_o,
        output ram_wr_o, ram_rd_o, ram_addr_o, ram_write_data_o,
        input  ram_read_data_i, ram_accept_i, ram_ack_i, ram_error_i
    );

    modport master (
        output req_wr_i, req_rd_i, req_addr_i, req_wdata_i,
        input  req_accept_o, req_ack_o, req_err_o, req_rdata_o,
        input  ram_wr_o, ram_rd_o, ram_addr_o, ram_write_data_o,
        output ram_read_data_i, ram_accept_i, ram_ack_i, ram_error_i
    );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first active index at or after ptr_i,
// wrapping modulo N.
module sdram_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     active_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int j;
        j       = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan from the farthest offset down so the nearest active one wins.
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (active_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM user port among NUM_REQ requesters,
// one transaction in flight, with an ack timeout that reports an error.
//
// state    | meaning
// IDLE     | no transaction; picks the next active requester
// ISSUE    | command on ram_*, waiting for ram_accept_i (no timeout)
// WAIT_ACK | command taken, counting toward TIMEOUT while awaiting ram_ack_i
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic           clk_ram,
    input  logic           rst_n,
    sdram_arbiter_if.slave bus
);

    localparam int              PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t               state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         grant_q, grant_d;
    logic                     grant_rd_q, grant_rd_d;
    logic [TO_W-1:0]          cnt_q, cnt_d;
    ram_cmd_t                 cmd_q, cmd_d;
    logic [NUM_REQ-1:0]       accept_q, accept_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [NUM_REQ-1:0]       err_q, err_d;
    logic [RAM_DATA_W-1:0]    rdata_q, rdata_d;

    logic [NUM_REQ-1:0]       active;
    logic                     pick_valid;
    logic [PTR_W-1:0]         pick_idx;
    logic [3:0]               sel_wr;
    logic                     sel_rd;
    logic [RAM_ADDR_W-1:0]    sel_addr;
    logic [RAM_DATA_W-1:0]    sel_wdata;

    always_comb begin
        active = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            active[k] = req_active(bus.req_wr_i[4*k +: 4], bus.req_rd_i[k]);
        end
    end

    sdram_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .active_i (active),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

    assign sel_wr    = bus.req_wr_i[{pick_idx, 2'b00} +: 4];
    // A write strobe overrides a simultaneous read request.
    assign sel_rd    = bus.req_rd_i[pick_idx] & ~(|sel_wr);
    assign sel_addr  = bus.req_addr_i[{pick_idx, 5'b00000} +: RAM_ADDR_W];
    assign sel_wdata = bus.req_wdata_i[{pick_idx, 5'b00000} +: RAM_DATA_W];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_rd_d = grant_rd_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        accept_d   = '0;
        ack_d      = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cmd_d.wr           = sel_wr;
                    cmd_d.rd           = sel_rd;
                    cmd_d.addr         = sel_addr;
                    cmd_d.wdata        = sel_wdata;
                    accept_d[pick_idx] = 1'b1;
                    grant_d            = pick_idx;
                    grant_rd_d         = sel_rd;
                    ptr_d              = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ram_accept_i) begin
                    cmd_d.wr = '0;
                    cmd_d.rd = 1'b0;
                    cnt_d    = '0;
                    if (bus.ram_ack_i) begin
                        ack_d[grant_q] = 1'b1;
                        err_d[grant_q] = bus.ram_error_i;
                        rdata_d        = grant_rd_q ? bus.ram_read_data_i : '0;
                        state_d        = IDLE;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.ram_ack_i) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = bus.ram_error_i;
                    rdata_d        = grant_rd_q ? bus.ram_read_data_i : '0;
                    state_d        = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    rdata_d        = '0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_rd_q <= 1'b0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            accept_q   <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_rd_q <= grant_rd_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            accept_q   <= accept_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.req_accept_o     = accept_q;
    assign bus.req_ack_o        = ack_q;
    assign bus.req_err_o        = err_q;
    assign bus.req_rdata_o      = rdata_q;
    assign bus.ram_wr_o         = cmd_q.wr;
    assign bus.ram_rd_o         = cmd_q.rd;
    assign bus.ram_addr_o       = cmd_q.addr;
    assign bus.ram_write_data_o = cmd_q.wdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round robin, read/write completion, error,
// timeout, same-cycle accept/ack and mid-transaction reset.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 10;
    localparam int TO_W    = 4;

    logic clk_ram = 1'b0;
    logic rst_n   = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   ack_total = 0;

    sdram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    sdram_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk_ram (clk_ram),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_ram = ~clk_ram;

    always @(negedge clk_ram) ack_total += $countones(bus.req_ack_o);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_wr_i[4*k +: 4]     = wr;
        bus.req_rd_i[k]            = rd;
        bus.req_addr_i[32*k +: 32] = addr;
        bus.req_wdata_i[32*k +: 32] = wdata;
    endtask

    task automatic clear_req(input int k);
        set_req(k, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // Returns with the accept pulse visible; checks it arrived within a bound.
    task automatic wait_accept(output int k_got);
        logic seen;
        seen  = 1'b0;
        k_got = -1;
        for (int n = 0; n < 20; n++) begin
            if (|bus.req_accept_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        for (int j = 0; j < NUM_REQ; j++) if (bus.req_accept_o[j]) k_got = j;
        check_eq("accept_seen", 64'(seen), 64'd1);
    endtask

    // Controller side of a transaction already accepted by requester k.
    task automatic finish_txn(input int k, input int acc_dly, input int ack_dly,
                              input logic rerr, input logic [31:0] rdat,
                              input logic [31:0] exp_rdata, input string tag);
        repeat (acc_dly) step();
        bus.ram_accept_i = 1'b1;
        if (ack_dly == 0) begin
            bus.ram_ack_i       = 1'b1;
            bus.ram_error_i     = rerr;
            bus.ram_read_data_i = rdat;
        end
        step();
        bus.ram_accept_i = 1'b0;
        check_eq({tag, "_accept_1shot"}, 64'(bus.req_accept_o), 64'd0);
        if (ack_dly != 0) begin
            check_eq({tag, "_cmd_clr"}, 64'({bus.ram_wr_o, bus.ram_rd_o}), 64'd0);
            repeat (ack_dly - 1) step();
            bus.ram_ack_i       = 1'b1;
            bus.ram_error_i     = rerr;
            bus.ram_read_data_i = rdat;
            step();
        end
        bus.ram_ack_i   = 1'b0;
        bus.ram_error_i = 1'b0;
        check_eq({tag, "_ack"},   64'(bus.req_ack_o), 64'd1 << k);
        check_eq({tag, "_err"},   64'(bus.req_err_o), 64'(rerr) << k);
        check_eq({tag, "_rdata"}, 64'(bus.req_rdata_o), 64'(exp_rdata));
        step();
        check_eq({tag, "_ack_1shot"}, 64'(bus.req_ack_o), 64'd0);
    endtask

    initial begin
        int k;
        int early;
        int a0;

        bus.req_wr_i        = '0;
        bus.req_rd_i        = '0;
        bus.req_addr_i      = '0;
        bus.req_wdata_i     = '0;
        bus.ram_read_data_i = '0;
        bus.ram_accept_i    = 1'b0;
        bus.ram_ack_i       = 1'b0;
        bus.ram_error_i     = 1'b0;

        repeat (3) step();
        check_eq("reset_cmd",    64'({bus.ram_wr_o, bus.ram_rd_o}), 64'd0);
        check_eq("reset_addr",   64'(bus.ram_addr_o), 64'd0);
        check_eq("reset_pulses", 64'({bus.req_accept_o, bus.req_ack_o, bus.req_err_o}), 64'd0);
        check_eq("reset_rdata",  64'(bus.req_rdata_o), 64'd0);
        rst_n = 1'b1;
        step();

        // All requesters held active: grants rotate 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'h0, 1'b1, 32'h1000 + 32'(16 * i), 32'h0);
        for (int n = 0; n < 5; n++) begin
            wait_accept(k);
            check_eq($sformatf("rr_grant%0d", n), 64'(k), 64'(n % 4));
            check_eq($sformatf("rr_onehot%0d", n), 64'(bus.req_accept_o), 64'd1 << (n % 4));
            check_eq($sformatf("rr_addr%0d", n), 64'(bus.ram_addr_o), 64'(32'h1000 + 32'(16 * (n % 4))));
            if (n == 4) for (int i = 0; i < NUM_REQ; i++) clear_req(i);
            finish_txn(n % 4, 0, 0, 1'b0, 32'hA5A5_0000 + 32'(n), 32'hA5A5_0000 + 32'(n), "rr");
        end

        // Write with strobes 0011 from requester 2, controller reports error.
        set_req(2, 4'b0011, 1'b0, 32'h2000, 32'h55AA_1234);
        wait_accept(k);
        check_eq("wr_grant", 64'(k), 64'd2);
        check_eq("wr_strobe", 64'(bus.ram_wr_o), 64'h3);
        check_eq("wr_rd_low", 64'(bus.ram_rd_o), 64'd0);
        check_eq("wr_wdata", 64'(bus.ram_write_data_o), 64'h55AA_1234);
        clear_req(2);
        finish_txn(2, 0, 2, 1'b1, 32'h1234_5678, 32'h0, "wr");

        // Single read from requester 1.
        set_req(1, 4'h0, 1'b1, 32'h100, 32'h0);
        wait_accept(k);
        check_eq("rd_grant", 64'(k), 64'd1);
        check_eq("rd_cmd", 64'({bus.ram_wr_o, bus.ram_rd_o}), 64'd1);
        check_eq("rd_addr", 64'(bus.ram_addr_o), 64'h100);
        clear_req(1);
        finish_txn(1, 1, 3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd");

        // Accepted but never acked: error after TIMEOUT cycles, stray ack ignored.
        set_req(0, 4'h0, 1'b1, 32'h300, 32'h0);
        wait_accept(k);
        check_eq("to_grant", 64'(k), 64'd0);
        clear_req(0);
        bus.ram_accept_i = 1'b1;
        step();
        bus.ram_accept_i = 1'b0;
        early = 0;
        repeat (TIMEOUT - 1) begin
            step();
            early += $countones(bus.req_ack_o);
        end
        check_eq("to_no_early_ack", 64'(early), 64'd0);
        step();
        check_eq("to_ack",   64'(bus.req_ack_o), 64'h1);
        check_eq("to_err",   64'(bus.req_err_o), 64'h1);
        check_eq("to_rdata", 64'(bus.req_rdata_o), 64'h0);
        step();
        a0 = ack_total;
        bus.ram_ack_i       = 1'b1;
        bus.ram_read_data_i = 32'h0BAD_0BAD;
        step();
        bus.ram_ack_i = 1'b0;
        repeat (3) step();
        check_eq("stray_ack_ignored", 64'(ack_total), 64'(a0));
        check_eq("rdata_hold", 64'(bus.req_rdata_o), 64'h0);

        // Same-cycle accept and ack; next requester granted right after.
        set_req(3, 4'h0, 1'b1, 32'h400, 32'h0);
        wait_accept(k);
        check_eq("same_grant", 64'(k), 64'd3);
        clear_req(3);
        set_req(1, 4'h0, 1'b1, 32'h500, 32'h0);
        finish_txn(3, 0, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, "same");
        check_eq("b2b_accept", 64'(bus.req_accept_o), 64'h2);
        check_eq("b2b_addr", 64'(bus.ram_addr_o), 64'h500);
        clear_req(1);
        finish_txn(1, 1, 1, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF, "b2b");

        // Reset during WAIT_ACK aborts without ack; pointer returns to 0.
        set_req(2, 4'h0, 1'b1, 32'h600, 32'h0);
        wait_accept(k);
        check_eq("rst_grant", 64'(k), 64'd2);
        clear_req(2);
        bus.ram_accept_i = 1'b1;
        step();
        bus.ram_accept_i = 1'b0;
        step();
        step();
        a0 = ack_total;
        rst_n = 1'b0;
        #1;
        check_eq("rst_cmd",    64'({bus.ram_wr_o, bus.ram_rd_o}), 64'd0);
        check_eq("rst_addr",   64'(bus.ram_addr_o), 64'd0);
        check_eq("rst_rdata",  64'(bus.req_rdata_o), 64'd0);
        check_eq("rst_pulses", 64'({bus.req_accept_o, bus.req_ack_o, bus.req_err_o}), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        bus.ram_ack_i       = 1'b1;
        bus.ram_read_data_i = 32'h7777_7777;
        step();
        bus.ram_ack_i = 1'b0;
        step();
        check_eq("late_ack_ignored", 64'(ack_total), 64'(a0));
        set_req(0, 4'h0, 1'b1, 32'h700, 32'h0);
        set_req(3, 4'h0, 1'b1, 32'h800, 32'h0);
        wait_accept(k);
        check_eq("ptr_after_reset", 64'(k), 64'd0);
        check_eq("ptr_reset_addr", 64'(bus.ram_addr_o), 64'h700);
        clear_req(0);
        clear_req(3);
        finish_txn(0, 0, 1, 1'b0, 32'h2468_ACE0, 32'h2468_ACE0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
